// File: rtl/pwm_pkg.sv
// pwm_pkg: shared width/depth defaults and the per-channel edge-pair type.
package pwm_pkg;

    localparam int WIDTH_DEF = 13;
    localparam int DEPTH_DEF = 249;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] rise;
        logic [WIDTH_DEF-1:0] fall;
        logic                 full_width;
    } edge_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// pwm_edge_calc: two-stage pipeline turning one (cycle, duty, phase) entry into rise/fall edges.
module pwm_edge_calc
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] cycle,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] phase,
    output logic             out_valid,
    output edge_t            edge_o
);

    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, p_q, p_d, cyc_q, cyc_d;
    logic [WIDTH-1:0] dc, rise_w, fall_w;
    logic [WIDTH:0]   rise_raw, fall_raw;

    always_comb begin
        dc      = (duty < cycle) ? duty : cycle;
        lo_d    = dc >> 1;
        hi_d    = dc - lo_d;
        p_d     = (phase >= cycle) ? phase - cycle : phase;
        full_d  = duty >= cycle;
        cyc_d   = cycle;
        valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        full_q <= full_d;
        lo_q   <= lo_d;
        hi_q   <= hi_d;
        p_q    <= p_d;
        cyc_q  <= cyc_d;
    end

    // Results always land in [0, cycle), so the low WIDTH bits wrap correctly.
    always_comb begin
        rise_raw           = {1'b0, p_q} - {1'b0, lo_q};
        fall_raw           = {1'b0, p_q} + {1'b0, hi_q};
        rise_w             = rise_raw[WIDTH] ? rise_raw[WIDTH-1:0] + cyc_q : rise_raw[WIDTH-1:0];
        fall_w             = (fall_raw >= {1'b0, cyc_q}) ? fall_raw[WIDTH-1:0] - cyc_q : fall_raw[WIDTH-1:0];
        edge_o.rise        = full_q ? '0 : WIDTH_DEF'(rise_w);
        edge_o.fall        = full_q ? '0 : WIDTH_DEF'(fall_w);
        edge_o.full_width  = full_q;
    end

    assign out_valid = valid_q;

endmodule

// File: rtl/pwm_preconditioner.sv
// pwm_preconditioner: stages a full set of per-channel PWM edges and swaps it in atomically.
// Define PWM_PRECOND_SYNC_EN to hold the swap until the shared time counter wraps to zero.
module pwm_preconditioner
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             TIME_CNT,
    input  logic                         DIN_VALID,
    output logic                         DIN_READY,
    input  logic [WIDTH-1:0]             CYCLE,
    input  logic [WIDTH-1:0]             DUTY,
    input  logic [WIDTH-1:0]             PHASE,
    output logic [DEPTH-1:0][WIDTH-1:0]  RISE,
    output logic [DEPTH-1:0][WIDTH-1:0]  FALL,
    output logic [DEPTH-1:0]             FULL_WIDTH,
    output logic                         COMMIT
);

    localparam int            IW   = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    logic          ready_q, ready_d, pending_q, pending_d, commit_q, commit_d;
    logic [IW-1:0] acc_q, acc_d, wr_q, wr_d;
    logic          accept, new_valid, wr_last, commit_go;
    edge_t         new_edge;
    edge_t         stage_q [DEPTH];
    edge_t         stage_d [DEPTH];
    edge_t         active_q [DEPTH];
    edge_t         active_d [DEPTH];

    pwm_edge_calc #(.WIDTH(WIDTH)) u_calc (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (accept),
        .cycle     (CYCLE),
        .duty      (DUTY),
        .phase     (PHASE),
        .out_valid (new_valid),
        .edge_o    (new_edge)
    );

`ifdef PWM_PRECOND_SYNC_EN
    assign commit_go = pending_q && (TIME_CNT == '0);
`else
    logic unused_time;
    assign unused_time = ^TIME_CNT;
    assign commit_go   = pending_q;
`endif

    always_comb begin
        accept    = DIN_VALID && ready_q;
        acc_d     = accept ? ((acc_q == LAST) ? '0 : acc_q + 1'b1) : acc_q;
        ready_d   = commit_q ? 1'b1 : (accept && acc_q == LAST) ? 1'b0 : ready_q;
        wr_last   = new_valid && (wr_q == LAST);
        wr_d      = new_valid ? (wr_last ? '0 : wr_q + 1'b1) : wr_q;
        pending_d = wr_last ? 1'b1 : commit_go ? 1'b0 : pending_q;
        commit_d  = commit_go;
        stage_d   = stage_q;
        if (new_valid) stage_d[wr_q] = new_edge;
        active_d  = active_q;
        if (commit_go) active_d = stage_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            acc_q     <= '0;
            wr_q      <= '0;
            active_q  <= '{default: '0};
        end else begin
            ready_q   <= ready_d;
            pending_q <= pending_d;
            commit_q  <= commit_d;
            acc_q     <= acc_d;
            wr_q      <= wr_d;
            active_q  <= active_d;
        end
        stage_q <= stage_d;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_out
        assign RISE[i]       = WIDTH'(active_q[i].rise);
        assign FALL[i]       = WIDTH'(active_q[i].fall);
        assign FULL_WIDTH[i] = active_q[i].full_width;
    end

    assign DIN_READY = ready_q;
    assign COMMIT    = commit_q;

endmodule

// File: doc/pwm_preconditioner.md
PWM_PRECONDITIONER -- requirements
Module: pwm_preconditioner

Interface
REQ-001 Parameter WIDTH, default 13: bit width of time counter, cycle, duty, phase, rise and fall values.
REQ-002 Parameter DEPTH, default 249: number of transducer channels.
REQ-003 The block SHALL have one clock, CLK; reset is synchronous and active-high, port RST.
REQ-004 CLK  in  1  system clock.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 TIME_CNT  in  WIDTH  shared PWM time counter.
REQ-007 DIN_VALID  in  1  input entry valid.
REQ-008 DIN_READY  out  1  input entry accepted when DIN_VALID & DIN_READY.
REQ-009 CYCLE, DUTY, PHASE  in  WIDTH each  per-entry period, pulse width and phase, in channel order 0..DEPTH-1.
REQ-010 RISE, FALL  out  DEPTH x WIDTH  active per-channel edge times for the PWM stage.
REQ-011 FULL_WIDTH  out  DEPTH  per-channel constant-high flag.
REQ-012 COMMIT  out  1  one-cycle pulse when a new set becomes active.

Function
REQ-013 Stage 1 SHALL compute dc = min(DUTY, CYCLE), lo = dc>>1, hi = dc-lo, and p = PHASE-CYCLE if PHASE >= CYCLE, else PHASE (single subtraction; contract PHASE < 2*CYCLE).
REQ-014 Stage 2 SHALL compute RISE = p-lo, adding CYCLE if negative, and FALL = p+hi, subtracting CYCLE if >= CYCLE, using WIDTH+1-bit intermediates.
REQ-015 DUTY >= CYCLE SHALL yield FULL_WIDTH=1, RISE=0, FALL=0.
REQ-016 DUTY = 0 SHALL yield RISE = FALL = p, FULL_WIDTH=0.
REQ-017 Accepted entry to staging-buffer write latency SHALL be exactly 2 cycles; one entry per cycle sustained.
REQ-018 Entries SHALL be written to staging index 0..DEPTH-1 in acceptance order; index wraps to 0 after DEPTH-1.
REQ-019 DIN_READY SHALL drop the cycle after the DEPTH-th entry is accepted and stay low until the cycle after COMMIT.
REQ-020 PENDING SHALL be set on the cycle the DEPTH-th entry is written to staging.
REQ-021 Commit SHALL occur on the first cycle with PENDING registered high and TIME_CNT == 0; all RISE/FALL/FULL_WIDTH outputs update together on the next edge, COMMIT pulses on that same edge, PENDING clears.
REQ-022 PENDING setting in the same cycle as TIME_CNT == 0 SHALL not commit; commit waits for the next wrap.
REQ-023 Active outputs SHALL never change except at commit or reset; no partially-updated set is ever visible.

Reset
REQ-024 RST SHALL clear RISE, FALL, FULL_WIDTH, COMMIT, PENDING, pipeline valids and write index to 0, and set DIN_READY = 1 the cycle after release.
REQ-025 RST mid-load SHALL discard all staged entries; active outputs return to 0.

Configuration
REQ-026 Macro PWM_PRECOND_SYNC_EN defined: commit per REQ-021/REQ-022.
REQ-027 PWM_PRECOND_SYNC_EN undefined: commit SHALL occur on the first cycle PENDING is registered high, ignoring TIME_CNT.

Structure
REQ-028 Shared package pwm_pkg SHALL hold the WIDTH/DEPTH defaults and the edge-pair struct type (rise, fall, full_width).
REQ-029 Sub-module pwm_edge_calc SHALL implement the 2-stage arithmetic pipeline (REQ-013..REQ-017) for one entry; top holds handshake, staging, active registers and commit control.

Verification
REQ-030 CYCLE=4096, DUTY=2048, PHASE=0 -> RISE=3072, FALL=1024, FULL_WIDTH=0.
REQ-031 CYCLE=4096, DUTY=500, PHASE=4000 -> RISE=3750, FALL=154; DUTY=5, PHASE=10 -> RISE=8, FALL=13.
REQ-032 CYCLE=4096, DUTY=4096 and DUTY=0 with PHASE=100 -> (FULL_WIDTH=1, 0, 0) and (0, RISE=FALL=100).
REQ-033 Load DEPTH entries with TIME_CNT mid-period -> DIN_READY low, outputs unchanged until TIME_CNT=0, then COMMIT and all channels update on one edge; DIN_READY high next cycle.
REQ-034 PENDING set in the same cycle as TIME_CNT=0 -> no commit until the following wrap; with macro undefined -> commit one cycle after PENDING.
REQ-035 Assert RST after 100 of 249 entries -> outputs 0; fresh full load commits only the new values.
